// File: rtl/spn_pkg.sv
// -----------------------------------------------------------------------------
// spn_pkg
// Shared definitions for the streaming permutation network (spn / spn_inv).
//   LANES           words carried per beat
//   DEF_DATA_WIDTH  default lane word width
//   word_t          one lane word at the default width
//   rd_state_t      read-side FSM state of spn_inv (also on its debug port)
//   stride_addr()   buffered-word index read for output position i
// -----------------------------------------------------------------------------
package spn_pkg;

  localparam int LANES          = 4;
  localparam int DEF_DATA_WIDTH = 16;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

  // Output position i takes buffered word (i mod S)*(F/S) + (i div S).
  // With F and S powers of two this is a rotation of the log2 index bits,
  // so only masks and shifts are needed.
  function automatic int unsigned stride_addr(input int unsigned i,
                                               input int unsigned frame_len,
                                               input int unsigned stride);
    int unsigned lg_s;
    int unsigned lg_f;
    lg_s = $clog2(stride);
    lg_f = $clog2(frame_len);
    return ((i & (stride - 1)) << (lg_f - lg_s)) | (i >> lg_s);
  endfunction

endpackage

// File: rtl/spn_inv_bank.sv
// -----------------------------------------------------------------------------
// spn_inv_bank
// One frame of word storage. Writes a whole beat (LANES words) at the beat
// address; LANES independent combinational read ports.
//   clk      in   clock
//   i_we     in   write enable for the beat at i_wbeat
//   i_wbeat  in   beat address (words LANES*i_wbeat .. LANES*i_wbeat+LANES-1)
//   i_wdata  in   beat data, lane l -> word LANES*i_wbeat+l
//   i_raddr  in   per-lane word read address
//   o_rdata  out  per-lane read data
// Contents are not reset: a frame is always fully written before it is read.
// -----------------------------------------------------------------------------
module spn_inv_bank
  import spn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 64,
  parameter int BW         = $clog2(FRAME_LEN / 4),
  parameter int AW         = $clog2(FRAME_LEN)
) (
  input  logic                                clk,
  input  logic                                i_we,
  input  logic [BW-1:0]                       i_wbeat,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]    i_wdata,
  input  logic [LANES-1:0][AW-1:0]            i_raddr,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [FRAME_LEN];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int l = 0; l < LANES; l++) begin
        r_mem[{i_wbeat, 2'(l)}] <= i_wdata[l];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      o_rdata[l] = r_mem[i_raddr[l]];
    end
  end

endmodule

// File: rtl/spn_inv.sv
// -----------------------------------------------------------------------------
// spn_inv
// Inverse streaming stride permutation, ping-pong buffered, one beat/cycle.
// Optional feature macro: SPN_INV_BYPASS_EN (adds the bypass input; a frame
// flagged at its first beat is emitted in arrival order).
//   clk            in   clock
//   rst            in   asynchronous reset, active low
//   input_stream   in   LANES words; lane l of beat b is word 4b+l
//   valid_in       in   qualifies the beat presented on the NEXT cycle
//   bypass         in   (SPN_INV_BYPASS_EN only) per-frame pass-through
//   output_stream  out  LANES words; lane l of beat b is position 4b+l
//   valid_out      out  qualifies the beat presented on the NEXT cycle
//   o_dbg_state    out  read FSM state
// Handshake: valid-before-data, no ready. valid_x high in cycle t means the
// data bus carries a beat in cycle t+1. The sink must accept every beat.
// -----------------------------------------------------------------------------
module spn_inv
  import spn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 64,
  parameter int STRIDE     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]  input_stream,
  input  logic                              valid_in,
`ifdef SPN_INV_BYPASS_EN
  input  logic                              bypass,
`endif
  output logic [LANES-1:0][DATA_WIDTH-1:0]  output_stream,
  output logic                              valid_out,
  output rd_state_t                         o_dbg_state
);

  localparam int BEATS = FRAME_LEN / LANES;
  localparam int BW    = $clog2(BEATS);
  localparam int AW    = $clog2(FRAME_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // Write side
  logic            r_vin;
  logic [BW-1:0]   r_wr_cnt;
  logic            r_wr_bank;
  logic [1:0]      r_full;
  // Read side
  rd_state_t       r_rd_state;
  rd_state_t       w_nxt_state;
  logic [BW-1:0]   r_rd_cnt;
  logic            r_rd_bank;
  logic [LANES-1:0][DATA_WIDTH-1:0] r_out;

  logic            w_wr_done;
  logic [1:0]      w_set_mask;
  logic [1:0]      w_clr_mask;
  logic [1:0]      w_full_now;
  logic            w_rd_last;
  logic [1:0]      w_we;
  logic            w_byp_sel;
  logic [LANES-1:0][AW-1:0]         w_raddr;
  logic [LANES-1:0][DATA_WIDTH-1:0] w_rdata [2];
  logic [LANES-1:0][DATA_WIDTH-1:0] w_rd_data;

  assign w_wr_done  = r_vin && (r_wr_cnt == LAST_BEAT);
  assign w_set_mask = w_wr_done ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_rd_last  = (r_rd_state == RD_DRAIN) && (r_rd_cnt == LAST_BEAT);
  assign w_clr_mask = w_rd_last ? (2'b01 << r_rd_bank) : 2'b00;
  // A frame completing this cycle counts as full, so its drain can start
  // (or chain onto the previous drain) without a bubble.
  assign w_full_now = r_full | w_set_mask;
  assign w_we[0]    = r_vin && !r_wr_bank;
  assign w_we[1]    = r_vin &&  r_wr_bank;

`ifdef SPN_INV_BYPASS_EN
  logic [1:0] r_byp;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byp <= 2'b00;
    end else if (r_vin && (r_wr_cnt == '0)) begin
      r_byp[r_wr_bank] <= bypass;
    end
  end
  assign w_byp_sel = r_byp[r_rd_bank];
`else
  assign w_byp_sel = 1'b0;
`endif

  // Write counter, bank select and full flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vin     <= 1'b0;
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_full    <= 2'b00;
    end else begin
      r_vin  <= valid_in;
      r_full <= (r_full & ~w_clr_mask) | w_set_mask;
      if (r_vin) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wr_done) r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Read FSM: banks fill and drain strictly alternately, so the bank to
  // drain next is always r_rd_bank (the older one).
  always_comb begin
    w_nxt_state = r_rd_state;
    case (r_rd_state)
      RD_IDLE:  if (w_full_now[r_rd_bank]) w_nxt_state = RD_DRAIN;
      RD_DRAIN: if (w_rd_last && !w_full_now[~r_rd_bank]) w_nxt_state = RD_IDLE;
      default:  w_nxt_state = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_state <= RD_IDLE;
      r_rd_cnt   <= '0;
      r_rd_bank  <= 1'b0;
      r_out      <= '0;
    end else begin
      r_rd_state <= w_nxt_state;
      if (r_rd_state == RD_DRAIN) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
        r_out    <= w_rd_data;
        if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Read addresses: position i = {beat, lane}
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      if (w_byp_sel) begin
        w_raddr[l] = {r_rd_cnt, 2'(l)};
      end else begin
        w_raddr[l] = AW'(stride_addr(32'({r_rd_cnt, 2'(l)}), FRAME_LEN, STRIDE));
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    spn_inv_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAME_LEN  (FRAME_LEN)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_we[b]),
      .i_wbeat (r_wr_cnt),
      .i_wdata (input_stream),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata[b])
    );
  end

  assign w_rd_data     = r_rd_bank ? w_rdata[1] : w_rdata[0];
  assign output_stream = r_out;
  assign valid_out     = (r_rd_state == RD_DRAIN) && rst;
  assign o_dbg_state   = r_rd_state;

endmodule

// File: tb/tb_spn_inv.sv
module tb_spn_inv;
  import spn_pkg::*;

  localparam int DW    = 16;
  localparam int FL    = 64;
  localparam int S     = 4;
  localparam int BEATS = FL / 4;
  localparam int W     = 4 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0][DW-1:0] input_stream;
  logic [3:0][DW-1:0] output_stream;
  logic               valid_in;
  logic               valid_out;
  rd_state_t          dbg_state;
`ifdef SPN_INV_BYPASS_EN
  logic               bypass;
`endif

  spn_inv #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .STRIDE(S)) dut (
    .clk           (clk),
    .rst           (rst),
    .input_stream  (input_stream),
    .valid_in      (valid_in),
`ifdef SPN_INV_BYPASS_EN
    .bypass        (bypass),
`endif
    .output_stream (output_stream),
    .valid_out     (valid_out),
    .o_dbg_state   (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         prev_vo = 1'b0;
  int           vo_cycles = 0;
  int           vo_runs = 0;
  int           first_vo_cyc = -1;
  logic [W-1:0] got_q[$];

  always @(negedge clk) begin
    if (prev_vo) got_q.push_back(output_stream);
    if (valid_out) begin
      vo_cycles++;
      if (!prev_vo) begin
        vo_runs++;
        first_vo_cyc = cyc;
      end
    end
    prev_vo = valid_out;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           rd_idx = 0;
  logic [DW-1:0] frm  [FL];
  logic [DW-1:0] orig [FL];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: output position i carries frame word (i mod S)*(FL/S) + i/S,
  // or word i when the frame is passed through.
  task automatic push_model(input bit byp);
    logic [W-1:0] bt;
    int src;
    for (int b = 0; b < BEATS; b++) begin
      for (int l = 0; l < 4; l++) begin
        src = byp ? (4 * b + l) : (((4 * b + l) % S) * (FL / S) + (4 * b + l) / S);
        bt[l*DW +: DW] = frm[src];
      end
      exp_q.push_back(bt);
    end
  endtask

  task automatic check_output(input string tag);
    int n;
    int budget;
    logic [W-1:0] g;
    n = exp_q.size();
    budget = 0;
    while (got_q.size() < rd_idx + n && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    repeat (20) @(negedge clk);
    chk({tag, "_count"}, W'(got_q.size() - rd_idx), W'(n));
    for (int k = 0; k < n; k++) begin
      g = (rd_idx + k < got_q.size()) ? got_q[rd_idx + k] : {W{1'bx}};
      chk(tag, g, exp_q[k]);
    end
    rd_idx = got_q.size();
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  logic         pend = 1'b0;
  logic [W-1:0] pend_data = '0;
  int           last_data_cyc = 0;

  function automatic logic [W-1:0] rand_beat();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [W-1:0] frm_beat(input int b);
    return {frm[4*b+3], frm[4*b+2], frm[4*b+1], frm[4*b]};
  endfunction

  // valid for the beat d is driven now; d itself goes out on the next step.
  task automatic step(input logic v, input logic [W-1:0] d);
    @(negedge clk);
    if (pend) begin
      input_stream  = pend_data;
      last_data_cyc = cyc + 1;
    end else begin
      input_stream = rand_beat();
    end
    valid_in  = v;
    pend      = v;
    pend_data = d;
  endtask

  task automatic send_frame(input bit gaps);
    for (int b = 0; b < BEATS; b++) begin
      step(1'b1, frm_beat(b));
      if (gaps) step(1'b0, '0);
    end
  endtask

  int vc0;
  int vr0;
  int base;
  logic [W-1:0] g0;
  logic [W-1:0] exp_first;

  initial begin
    valid_in     = 1'b0;
    input_stream = '0;
`ifdef SPN_INV_BYPASS_EN
    bypass       = 1'b0;
`endif

    // 1: reset held with live input traffic
    for (int c = 0; c < 12; c++) begin
      step(1'b1, rand_beat());
      chk("rst_valid_out", W'(valid_out), W'(0));
      chk("rst_output", output_stream, '0);
    end
    @(negedge clk);
    valid_in = 1'b0;
    pend     = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    chk("rst_state", W'(dbg_state), W'(RD_IDLE));

    // 2: single ramp frame
    for (int w = 0; w < FL; w++) frm[w] = DW'(w);
    push_model(1'b0);
    vc0 = vo_cycles; vr0 = vo_runs; base = rd_idx;
    send_frame(1'b0);
    step(1'b0, '0);
    check_output("t2_data");
    g0 = (got_q.size() > base) ? got_q[base] : {W{1'bx}};
    chk("t2_beat0", g0, {16'd48, 16'd32, 16'd16, 16'd0});
    chk("t2_latency", W'(first_vo_cyc), W'(last_data_cyc));
    chk("t2_vo_len", W'(vo_cycles - vc0), W'(16));
    chk("t2_vo_runs", W'(vo_runs - vr0), W'(1));
    chk("t2_idle", W'(dbg_state), W'(RD_IDLE));

    // 3+4: forward-permuted random frames, back-to-back -> identity, no bubble
    vc0 = vo_cycles; vr0 = vo_runs;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FL; i++) orig[i] = DW'($urandom_range(0, 65535));
      for (int i = 0; i < FL; i++) frm[(i % S) * (FL / S) + i / S] = orig[i];
      for (int b = 0; b < BEATS; b++)
        exp_q.push_back({orig[4*b+3], orig[4*b+2], orig[4*b+1], orig[4*b]});
      send_frame(1'b0);
    end
    step(1'b0, '0);
    check_output("t3_chain");
    chk("t4_vo_len", W'(vo_cycles - vc0), W'(48));
    chk("t4_vo_runs", W'(vo_runs - vr0), W'(1));

    // 5: ramp frame with valid_in low every other cycle
    for (int w = 0; w < FL; w++) frm[w] = DW'(w);
    push_model(1'b0);
    vc0 = vo_cycles; vr0 = vo_runs;
    send_frame(1'b1);
    step(1'b0, '0);
    check_output("t5_gaps");
    chk("t5_latency", W'(first_vo_cyc), W'(last_data_cyc));
    chk("t5_vo_len", W'(vo_cycles - vc0), W'(16));
    chk("t5_vo_runs", W'(vo_runs - vr0), W'(1));

    // 6: reset after 9 beats, then a fresh frame
    for (int b = 0; b < 9; b++) step(1'b1, rand_beat());
    step(1'b0, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    valid_in = 1'b0;
    pend     = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    for (int w = 0; w < FL; w++) frm[w] = DW'(100 + w);
`ifdef SPN_INV_BYPASS_EN
    bypass = 1'b1;
    push_model(1'b1);
    exp_first = {16'd103, 16'd102, 16'd101, 16'd100};
`else
    push_model(1'b0);
    exp_first = {16'd148, 16'd132, 16'd116, 16'd100};
`endif
    base = rd_idx;
    send_frame(1'b0);
    step(1'b0, '0);
    check_output("t6_after_rst");
    g0 = (got_q.size() > base) ? got_q[base] : {W{1'bx}};
    chk("t6_beat0", g0, exp_first);
    chk("t6_latency", W'(first_vo_cyc), W'(last_data_cyc));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
